// File: rtl/s386_resp_misr.sv
`default_nettype none
// ============================================================================
// Module   : s386_resp_misr
// Brief    : Windowed 7-bit MISR response compactor for the s386 outputs with
//            pass/fail compare against an expected signature at window end.
//            Optional input masking is enabled by defining S386_RESP_MASK_EN.
// Revision : 1.0  initial release
// ============================================================================
module s386_resp_misr #(
    parameter int         WIN_LEN = 256,
    parameter int         CNT_W   = 16,
    parameter logic [6:0] POLY    = 7'h03,
    parameter logic [6:0] SEED    = 7'h00
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [6:0]       resp,
    input  logic [6:0]       resp_mask,
    input  logic [6:0]       exp_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       sig,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_ARM  = 2'd1;
    localparam logic [1:0]       c_ST_RUN  = 2'd2;
    localparam logic [1:0]       c_ST_DONE = 2'd3;
    localparam logic [CNT_W-1:0] c_WIN_LEN = CNT_W'(WIN_LEN);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [6:0]       r_resp_q;
    logic [6:0]       w_resp_d;
    logic [6:0]       r_sig;
    logic [6:0]       w_sig_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;
    logic             r_pass;

`ifdef S386_RESP_MASK_EN
    // Masked bits enter the compactor as 0 so unknown responses cannot corrupt the signature.
    assign w_resp_d = resp & ~resp_mask;
`else
    assign w_resp_d = resp;
    wire w_unused_mask = &{1'b0, resp_mask};
`endif

    // Shift up, inject sample, and fold sig[6] back through the tap polynomial.
    assign w_sig_nxt = {r_sig[5:0], 1'b0} ^ r_resp_q ^ (POLY & {7{r_sig[6]}});
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == c_WIN_LEN);

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_ARM;
            c_ST_ARM:  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (start) w_state_nxt = c_ST_ARM;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_resp_q <= 7'h00;
            r_sig    <= SEED;
            r_cnt    <= '0;
            r_pass   <= 1'b0;
        end else begin
            r_resp_q <= w_resp_d;
            case (r_state)
                c_ST_ARM: begin
                    r_sig  <= SEED;
                    r_cnt  <= '0;
                    r_pass <= 1'b0;
                end
                c_ST_RUN: begin
                    // Guard keeps the counter saturated even if the window is already full.
                    if (r_cnt != c_WIN_LEN) begin
                        r_sig <= w_sig_nxt;
                        r_cnt <= w_cnt_inc;
                        if (w_last) r_pass <= (w_sig_nxt == exp_sig);
                    end
                end
                c_ST_DONE: begin
                    if (start) r_pass <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state == c_ST_ARM) || (r_state == c_ST_RUN);
    assign done    = (r_state == c_ST_DONE);
    assign pass    = r_pass & done;
    assign sig     = r_sig;
    assign cyc_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_s386_resp_misr.sv
`default_nettype none
// ============================================================================
// Module   : tb_s386_resp_misr
// Brief    : Scoreboard bench for s386_resp_misr with a 4-sample window.
// Revision : 1.0  initial release
// ============================================================================
module tb_s386_resp_misr;

    typedef struct packed {
        logic [6:0]  sig;
        logic        pass;
        logic [15:0] cnt;
    } exp_t;

    logic        CK;
    logic        RST;
    logic        start;
    logic [6:0]  resp;
    logic [6:0]  resp_mask;
    logic [6:0]  exp_sig;
    logic        busy;
    logic        done;
    logic        pass;
    logic [6:0]  sig;
    logic [15:0] cyc_cnt;

    int   n_vec;
    int   n_err;
    exp_t sb[$];

    s386_resp_misr #(
        .WIN_LEN (4),
        .CNT_W   (16),
        .POLY    (7'h03),
        .SEED    (7'h00)
    ) u_dut (
        .CK        (CK),
        .RST       (RST),
        .start     (start),
        .resp      (resp),
        .resp_mask (resp_mask),
        .exp_sig   (exp_sig),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .sig       (sig),
        .cyc_cnt   (cyc_cnt)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Reference compactor: x^7+x+1, seed 0, four samples packed 7 bits each.
    function automatic logic [6:0] misr_model(input logic [27:0] seq, input logic [6:0] msk);
        logic [6:0] s;
        logic [6:0] d;
        s = 7'h00;
        for (int k = 0; k < 4; k++) begin
            d = seq[7*k +: 7];
`ifdef S386_RESP_MASK_EN
            d = d & ~msk;
`else
            d = d | (msk & 7'h00);
`endif
            s = {s[5:0], 1'b0} ^ d ^ (7'h03 & {7{s[6]}});
        end
        return s;
    endfunction

    // Drives one full window; seq[6:0] is resp at edge 1, seq[27:21] at edge 4.
    task automatic run(input logic [27:0] seq, input logic [6:0] ex,
                       input logic [6:0] want_sig, input bit pulse_in_run);
        exp_t e;
        int   guard;
        e.sig  = want_sig;
        e.pass = (want_sig == ex);
        e.cnt  = 16'd4;
        sb.push_back(e);
        exp_sig = ex;
        start   = 1'b1;
        resp    = 7'h00;
        step();
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_pass_clr", 32'(pass), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            resp  = (k <= 4) ? seq[7*(k-1) +: 7] : 7'h00;
            start = pulse_in_run && (k == 2);
            step();
            if (k == 4) check("done_early", 32'(done), 32'd0);
        end
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin
            step();
            guard++;
        end
        check("done_latency", 32'(guard), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("final_sig", 32'(sig), 32'(e.sig));
            check("final_pass", 32'(pass), 32'(e.pass));
            check("final_cnt", 32'(cyc_cnt), 32'(e.cnt));
        end
    endtask

    initial begin
        logic [27:0] rseq;
        logic [6:0]  rsig;
        logic [6:0]  mask_want;
        logic [6:0]  hold_sig;
        n_vec     = 0;
        n_err     = 0;
        RST       = 1'b1;
        start     = 1'b0;
        resp      = 7'h00;
        resp_mask = 7'h00;
        exp_sig   = 7'h00;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_cnt", 32'(cyc_cnt), 32'd0);
        @(negedge CK);
        RST = 1'b0;
        step();

        // All-zero response window.
        run(28'h0000000, 7'h00, 7'h00, 1'b0);
        hold_sig = sig;
        step();
        step();
        check("done_hold", 32'(done), 32'd1);
        check("sig_hold", 32'(sig), 32'(hold_sig));
        check("pass_hold", 32'(pass), 32'd1);

        // Single 1 on bit0 walks up: 01,02,04,08.
        run(28'h0000001, 7'h08, 7'h08, 1'b0);
        run(28'h0000001, 7'h09, 7'h08, 1'b0);
        // Bit6 exercises feedback: 40,03,06,0C; start pulsed mid-run is ignored.
        run(28'h0000040, 7'h0C, 7'h0C, 1'b1);
        // Back-to-back from a passing DONE: pass must clear on entry to ARM.
        run(28'h0000040, 7'h0C, 7'h0C, 1'b0);

        // Reset in the middle of a run.
        start = 1'b1;
        resp  = 7'h7F;
        step();
        start = 1'b0;
        step();
        step();
        RST = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sig", 32'(sig), 32'd0);
        check("abort_cnt", 32'(cyc_cnt), 32'd0);
        resp = 7'h00;
        @(negedge CK);
        RST = 1'b0;
        step();
        check("abort_idle", 32'(busy), 32'd0);
        run(28'h0000000, 7'h00, 7'h00, 1'b0);

        // Masked bit6.
`ifdef S386_RESP_MASK_EN
        mask_want = 7'h00;
`else
        mask_want = 7'h0C;
`endif
        resp_mask = 7'h40;
        run(28'h0000040, 7'h00, mask_want, 1'b0);
        resp_mask = 7'h00;

        // Pseudo-random windows against the reference model.
        for (int i = 0; i < 4; i++) begin
            rseq = 28'($urandom);
            rsig = misr_model(rseq, resp_mask);
            run(rseq, (i[0]) ? (rsig ^ 7'h01) : rsig, rsig, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s386_resp_misr.md
# s386_resp_misr

Downstream response compactor for the s386 controller. Consumes the seven primary outputs v13_D_6..v13_D_12 and folds a programmable window of cycles into a 7-bit multiple-input signature register (MISR). At window end it compares the signature against an expected value and reports pass/fail. It is used for self-check runs without storing per-cycle traces.

## Interface
- WIN_LEN, 256: number of compacted samples per run; legal range 1..2^CNT_W-1.
- CNT_W, 16: width of the sample counter.
- POLY, 7'h03: feedback taps (x^7+x+1); bit i set means sig[6] is XORed into bit i.
- SEED, 7'h00: signature value loaded at run start.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  run request; sampled in IDLE and DONE only.
- resp  in  7  s386 outputs; bit0=v13_D_6 … bit6=v13_D_12.
- resp_mask  in  7  per-bit mask; a 1 forces that resp bit to 0 before compaction (see Configuration).
- exp_sig  in  7  expected signature; must be stable from the last update through DONE.
- busy  out  1  high in ARM and RUN.
- done  out  1  high in DONE.
- pass  out  1  registered (sig==exp_sig), valid while done=1, otherwise 0.
- sig  out  7  current signature register.
- cyc_cnt  out  CNT_W  number of updates performed in the current or last run.

## Operation
- resp_q is a 7-bit input register that loads resp on every edge, unconditionally. Masking, when enabled, is applied at this register's input.
- FSM states: IDLE, ARM, RUN, DONE.
  - IDLE: start=1 → ARM.
  - ARM: one cycle. Loads sig←SEED and cnt←0. Next state RUN.
  - RUN: every edge performs one update and increments cnt. If this update makes cnt equal WIN_LEN, go to DONE and register pass←(next_sig==exp_sig). start is ignored in RUN.
  - DONE: holds sig, cnt and pass. start=1 → ARM (re-run); otherwise stay.
- MISR update: next[i] = d[i] ^ (i>0 ? sig[i-1] : 0) ^ (POLY[i] & sig[6]), where d = resp_q.
- The run performs exactly WIN_LEN updates. cnt saturates at WIN_LEN and never wraps.
- Reset values: state IDLE, sig=SEED, cnt=0, resp_q=0, busy=0, done=0, pass=0.
- Reset asserted mid-run aborts the run immediately with no partial result. After release the FSM is in IDLE.
- In DONE, if start is asserted on the same edge that exp_sig changes, start wins: the FSM goes to ARM and pass is cleared to 0.

## Timing
- Start is sampled at edge 0 (IDLE→ARM). Edge 1 moves ARM→RUN and loads SEED. Edges 2..WIN_LEN+1 are updates. done rises after edge WIN_LEN+1.
- The compacted samples are resp as sampled at edges 1..WIN_LEN: one cycle of resp_q pipeline.
- Back-to-back runs: start held in DONE gives ARM on the next edge, so the gap between runs is 2 cycles.
- busy falls on the same edge that done rises. They are never high together.

## Configuration
- S386_RESP_MASK_EN defined: resp_q ← resp & ~resp_mask, so masked bits contribute 0 (X-tolerant compaction).
- Not defined: resp_mask is ignored and resp_q ← resp. The port remains present so the interface is identical.

## Test plan
- WIN_LEN=4, POLY=03, SEED=0, resp=0 throughout, exp_sig=00 → sig=00, done after edge 5, pass=1, cyc_cnt=4.
- WIN_LEN=4, resp=01 at edge 1 then 00 → sig steps 01,02,04,08. Final sig=08; with exp_sig=08 pass=1, with exp_sig=09 pass=0.
- WIN_LEN=4, resp=40 at edge 1 then 00 → feedback path gives sig 40,03,06,0C. Final sig=0C.
- Assert RST at edge 3 of a WIN_LEN=4 run → busy=0, done=0, sig=00, cnt=0 immediately. A new start then gives a clean run identical to the first scenario.
- With S386_RESP_MASK_EN: resp=40 at edge 1, resp_mask=40 → final sig=00, pass with exp_sig=00. Without the macro → final sig=0C.
- Hold start high in DONE → ARM next edge, pass cleared. start pulsed during RUN → no effect, cyc_cnt still ends at 4.
